// File: rtl/guitar_pkg.sv
// Shared types and constants for the magnitude peak detector.
// The optional threshold feature is selected with the PEAK_THRESHOLD_EN macro.
package guitar_pkg;

  localparam int FRAME_LEN_DEFAULT = 8192;
  localparam int BIN_W             = $clog2(FRAME_LEN_DEFAULT);

  typedef logic [31:0]      mag_t;
  typedef logic [BIN_W-1:0] bin_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } peak_state_e;

endpackage

// File: rtl/mag_argmax_reg.sv
// Running maximum / argmax register for one frame.
// clear_i restarts the search from the supplied seed value and index.
// en_i & in_window_i qualify a candidate; strict greater-than keeps the
// lowest index on ties. The next-state values are exported so the owner
// can capture a result that includes the beat being accepted this cycle.
module mag_argmax_reg
  import guitar_pkg::*;
#(
  parameter int IDX_W = BIN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  mag_t             clear_mag_i,
  input  logic [IDX_W-1:0] clear_idx_i,
  input  logic             en_i,
  input  logic             in_window_i,
  input  mag_t             mag_i,
  input  logic [IDX_W-1:0] idx_i,
  output mag_t             max_nxt_o,
  output logic [IDX_W-1:0] idx_nxt_o
);

  mag_t             max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Select restart seed, a strictly larger in-window candidate, or hold.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (clear_i) begin
      max_d = clear_mag_i;
      idx_d = clear_idx_i;
    end else if (en_i && in_window_i && (mag_i > max_q)) begin
      max_d = mag_i;
      idx_d = idx_i;
    end
  end

  // Running max/index storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  assign max_nxt_o = max_d;
  assign idx_nxt_o = idx_d;

endmodule

// File: rtl/magnitude_peak_detector.sv
// Per-frame peak search over an FFT magnitude stream.
// One bin arrives per mag_valid beat; mag_sop marks bin 0. The largest
// magnitude in bins below SCAN_BINS (optionally skipping DC) is reported
// with a one-cycle peak_valid after the last bin of the frame. An early
// sop aborts the frame with a frame_err pulse and restarts from that beat.
// Define PEAK_THRESHOLD_EN to make peak_found reflect max >= THRESHOLD;
// otherwise peak_found is a constant 1 out of reset.
// Handshake: mag_valid qualifies mag_sop/mag_data; there is no ready,
// every valid beat is consumed on the rising edge it is presented at.
module magnitude_peak_detector
  import guitar_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int SCAN_BINS = 4096,
  parameter int SKIP_DC   = 1
`ifdef PEAK_THRESHOLD_EN
  ,
  parameter logic [31:0] THRESHOLD = 32'h100
`endif
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         mag_valid,
  input  logic                         mag_sop,
  input  mag_t                         mag_data,
  output logic                         peak_valid,
  output logic [$clog2(FRAME_LEN)-1:0] peak_bin,
  output mag_t                         peak_mag,
  output logic                         peak_found,
  output logic                         frame_err,
  output peak_state_e                  dbg_state
);

  localparam int            BW        = $clog2(FRAME_LEN);
  localparam logic [BW-1:0] LAST_BIN  = BW'(FRAME_LEN - 1);
  localparam logic [BW-1:0] FIRST_BIN = (SKIP_DC != 0) ? BW'(1) : '0;
  localparam logic [BW:0]   SCAN_LIM  = (BW + 1)'(SCAN_BINS);

  peak_state_e   state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;

  logic          start_beat, abort_beat;
  logic          restart, scan_en, report, err;
  logic          in_window;
  mag_t          seed_mag;
  mag_t          max_nxt;
  logic [BW-1:0] idx_nxt;

  logic          peak_valid_q, frame_err_q, peak_found_q;
  logic [BW-1:0] peak_bin_q;
  mag_t          peak_mag_q;

  // sop mid-frame (not on the last bin) aborts; on the last bin it is ignored.
  assign start_beat = mag_valid & mag_sop;
  assign abort_beat = start_beat & (cnt_q != '0) & (cnt_q != LAST_BIN);
  assign in_window  = ({1'b0, cnt_q} < SCAN_LIM) && ((SKIP_DC == 0) || (cnt_q != '0));
  // With DC skipped the sop beat never competes, so the search seeds at 0.
  assign seed_mag   = (SKIP_DC != 0) ? '0 : mag_data;

  // State and bin counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: REPORT behaves like IDLE for an incoming sop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_beat) state_d = SCAN;
      SCAN:    if (mag_valid && !abort_beat && (cnt_q == LAST_BIN)) state_d = REPORT;
      REPORT:  state_d = start_beat ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control decode: restart/scan/report/error strobes and counter update.
  always_comb begin
    restart = 1'b0;
    scan_en = 1'b0;
    report  = 1'b0;
    err     = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, REPORT: begin
        if (start_beat) begin
          restart = 1'b1;
          cnt_d   = BW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      SCAN: begin
        if (abort_beat) begin
          restart = 1'b1;
          err     = 1'b1;
          cnt_d   = BW'(1);
        end else if (mag_valid) begin
          scan_en = 1'b1;
          if (cnt_q == LAST_BIN) begin
            report = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  mag_argmax_reg #(
    .IDX_W (BW)
  ) u_argmax (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (restart),
    .clear_mag_i (seed_mag),
    .clear_idx_i (FIRST_BIN),
    .en_i        (scan_en),
    .in_window_i (in_window),
    .mag_i       (mag_data),
    .idx_i       (cnt_q),
    .max_nxt_o   (max_nxt),
    .idx_nxt_o   (idx_nxt)
  );

  // Output registers: pulses for one cycle, peak fields hold until next report.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      peak_found_q <= 1'b0;
    end else begin
      peak_valid_q <= report;
      frame_err_q  <= err;
      if (report) begin
        peak_bin_q <= idx_nxt;
        peak_mag_q <= max_nxt;
`ifdef PEAK_THRESHOLD_EN
        peak_found_q <= (max_nxt >= THRESHOLD);
`endif
      end
`ifndef PEAK_THRESHOLD_EN
      peak_found_q <= 1'b1;
`endif
    end
  end

  assign peak_valid = peak_valid_q;
  assign frame_err  = frame_err_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign peak_found = peak_found_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_magnitude_peak_detector.sv
// Directed-plus-random bench for magnitude_peak_detector (default parameters).
`timescale 1ns/1ps
module tb_magnitude_peak_detector;
  import guitar_pkg::*;

  localparam int FL = 8192;
  localparam int SB = 4096;
  localparam int SD = 1;
  localparam int BW = $clog2(FL);
  localparam int EW = BW + 33;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        mag_valid = 1'b0;
  logic        mag_sop   = 1'b0;
  logic [31:0] mag_data  = '0;
  logic              peak_valid;
  logic [BW-1:0]     peak_bin;
  logic [31:0]       peak_mag;
  logic              peak_found;
  logic              frame_err;
  peak_state_e       dbg_state;

  magnitude_peak_detector dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mag_valid  (mag_valid),
    .mag_sop    (mag_sop),
    .mag_data   (mag_data),
    .peak_valid (peak_valid),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag),
    .peak_found (peak_found),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;
  int last_k   = 0;
  int first_k  = 0;

  logic [31:0]   frame_mem [FL];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int            exp_ncyc_q[$];
  int            obs_ncyc_q[$];
  int            exp_fe_q[$];
  int            obs_fe_q[$];

  // monitor: sample outputs on the falling edge
  always @(negedge clk) begin
    ncyc++;
    if (peak_valid === 1'b1) begin
      obs_q.push_back({peak_bin, peak_mag, peak_found});
      obs_ncyc_q.push_back(ncyc);
    end
    if (frame_err === 1'b1) obs_fe_q.push_back(ncyc);
  end

  // watchdog
  initial begin
    #1500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_beat(input logic sop, input logic [31:0] d);
    @(posedge clk); #1;
    mag_valid = 1'b1;
    mag_sop   = sop;
    mag_data  = d;
    last_k    = ncyc;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mag_valid = 1'b0;
      mag_sop   = 1'($urandom_range(0, 1));
      mag_data  = $urandom;
    end
  endtask

  task automatic send_bins(input int last, input int gap_pct, input logic last_sop);
    for (int i = 0; i <= last; i++) begin
      while ($urandom_range(0, 99) < gap_pct) drive_idle(1);
      drive_beat((i == 0) || ((i == last) && last_sop), frame_mem[i]);
      if (i == 0) first_k = last_k;
    end
  endtask

  task automatic fill_rand(input int hi);
    for (int i = 0; i < FL; i++) frame_mem[i] = $urandom_range(0, hi);
  endtask

  // reference: the largest value in the window, at its lowest index
  task automatic model_peak(output logic [BW-1:0] b, output logic [31:0] m);
    int lo;
    logic [31:0] mx;
    int at;
    lo = (SD != 0) ? 1 : 0;
    mx = '0;
    for (int i = lo; i < SB; i++) if (frame_mem[i] > mx) mx = frame_mem[i];
    at = -1;
    for (int i = lo; i < SB; i++) if (at < 0 && frame_mem[i] == mx) at = i;
    b = BW'(at);
    m = mx;
  endtask

  task automatic expect_frame();
    logic [BW-1:0] b;
    logic [31:0]   m;
    logic          f;
    model_peak(b, m);
`ifdef PEAK_THRESHOLD_EN
    f = (m >= 32'h100);
`else
    f = 1'b1;
`endif
    exp_q.push_back({b, m, f});
    exp_ncyc_q.push_back(last_k + 2);
  endtask

  // scoreboard compare
  task automatic check_reports(input string tag);
    logic [EW-1:0] o, e;
    int on, en;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o  = obs_q.pop_front();
      e  = exp_q.pop_front();
      on = obs_ncyc_q.pop_front();
      en = exp_ncyc_q.pop_front();
      chk({tag, "_bin"},   32'(o[EW-1 -: BW]), 32'(e[EW-1 -: BW]));
      chk({tag, "_mag"},   o[32:1], e[32:1]);
      chk({tag, "_found"}, 32'(o[0]), 32'(e[0]));
      chk({tag, "_lat"},   32'(on), 32'(en));
    end
    obs_q.delete(); exp_q.delete(); obs_ncyc_q.delete(); exp_ncyc_q.delete();
    chk({tag, "_ferr_count"}, 32'(obs_fe_q.size()), 32'(exp_fe_q.size()));
    while (obs_fe_q.size() > 0 && exp_fe_q.size() > 0)
      chk({tag, "_ferr_lat"}, 32'(obs_fe_q.pop_front()), 32'(exp_fe_q.pop_front()));
    obs_fe_q.delete(); exp_fe_q.delete();
  endtask

  initial begin
    int pos;
    // reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_peak_valid", 32'(peak_valid), 32'd0);
    chk("rst_peak_bin",   32'(peak_bin),   32'd0);
    chk("rst_peak_mag",   peak_mag,        32'd0);
    chk("rst_peak_found", 32'(peak_found), 32'd0);
    chk("rst_frame_err",  32'(frame_err),  32'd0);
    chk("rst_state",      32'(dbg_state),  32'(IDLE));
    reset_n = 1'b1;
    drive_idle(3);
`ifdef PEAK_THRESHOLD_EN
    chk("found_after_rst", 32'(peak_found), 32'd0);
`else
    chk("found_after_rst", 32'(peak_found), 32'd1);
`endif

    // valid beats without sop in IDLE are dropped
    repeat (4) drive_beat(1'b0, 32'hFFFF_FFFF);
    drive_idle(4);
    chk("idle_drop_state", 32'(dbg_state), 32'(IDLE));
    check_reports("idle_drop");

    // test 1: single tone, immediately followed by test 2 (REPORT->SCAN, sop on last bin)
    for (int i = 0; i < FL; i++) frame_mem[i] = 32'h10;
    frame_mem[440] = 32'h5000;
    send_bins(FL - 1, 0, 1'b0);
    expect_frame();
    fill_rand(32'h7FF);
    frame_mem[100] = 32'h800;
    frame_mem[200] = 32'h800;
    send_bins(FL - 1, 0, 1'b1);
    expect_frame();
    drive_idle(5);
    check_reports("tone_tie");

    // test 3: DC excluded, out-of-window bin ignored
    fill_rand(32'h3F);
    frame_mem[0]    = 32'hFFFF_FFFF;
    frame_mem[7]    = 32'h40;
    frame_mem[5000] = 32'h9999;
    send_bins(FL - 1, 0, 1'b0);
    expect_frame();
    drive_idle(5);
    check_reports("skip_dc");

    // test 4: early sop aborts, restarted frame reports
    fill_rand(32'hFFFF);
    send_bins(2999, 0, 1'b0);
    fill_rand(32'hFFFF);
    send_bins(FL - 1, 0, 1'b0);
    exp_fe_q.push_back(first_k + 2);
    expect_frame();
    drive_idle(5);
    check_reports("abort");

    // test 5: tone with random 50% gaps
    for (int i = 0; i < FL; i++) frame_mem[i] = 32'h10;
    frame_mem[440] = 32'h5000;
    send_bins(FL - 1, 50, 1'b0);
    expect_frame();
    drive_idle(5);
    check_reports("gaps");

    // threshold boundaries: max 0xFF then max 0x100
    fill_rand(32'hFE);
    pos = $urandom_range(1, SB - 1);
    frame_mem[pos] = 32'hFF;
    send_bins(FL - 1, 0, 1'b0);
    expect_frame();
    drive_idle(5);
    check_reports("thr_ff");
    fill_rand(32'hFF);
    pos = $urandom_range(1, SB - 1);
    frame_mem[pos] = 32'h100;
    send_bins(FL - 1, 0, 1'b0);
    expect_frame();
    drive_idle(5);
    check_reports("thr_100");

    // reset mid-frame: immediate clear, no pulses
    fill_rand(32'hFFFF);
    send_bins(1999, 0, 1'b0);
    #2;
    reset_n   = 1'b0;
    mag_valid = 1'b0;
    #1;
    chk("midrst_peak_valid", 32'(peak_valid), 32'd0);
    chk("midrst_peak_bin",   32'(peak_bin),   32'd0);
    chk("midrst_peak_mag",   peak_mag,        32'd0);
    chk("midrst_peak_found", 32'(peak_found), 32'd0);
    chk("midrst_frame_err",  32'(frame_err),  32'd0);
    chk("midrst_state",      32'(dbg_state),  32'(IDLE));
    drive_idle(4);
    reset_n = 1'b1;
    drive_idle(6);
    check_reports("midrst");

    // all-zero window: index is the first window bin
    fill_rand(0);
    send_bins(FL - 1, 0, 1'b0);
    expect_frame();
    drive_idle(5);
    check_reports("all_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
